// File: rtl/approx_mult_err_engine.sv
// approx_mult_err_engine: sweeps every W x W operand pair through an external
// approximate multiplier and accumulates error count, sum/max error distance
// and fixed-point relative error (one restoring-division quotient per pair).
module approx_mult_err_engine #(
    parameter int W       = 4,
    parameter int DUT_LAT = 1,
    parameter int FRAC    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [W-1:0]          a,
    output logic [W-1:0]          b,
    input  logic [2*W-1:0]        c,
    output logic                  busy,
    output logic                  done,
    output logic                  results_valid,
    output logic [2*W:0]          err_count,
    output logic [4*W:0]          sum_ed,
    output logic [2*W-1:0]        max_ed,
    output logic [4*W+FRAC-1:0]   sum_red,
    output logic [2*W+FRAC-1:0]   mred
);

    localparam int PW   = 2 * W;
    localparam int QW   = PW + FRAC;
    localparam int CMAX = (QW > DUT_LAT) ? QW : DUT_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_SAMPLE, S_DIV, S_ACCUM, S_DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   idx;      // sweep index; a/b are its two halves
    logic [CW-1:0]   cnt;      // settle / divide cycle counter
    logic [PW-1:0]   ed_r;     // error distance of the current pair
    logic [PW-1:0]   div_r;    // exact product, used as divisor
    logic [PW-1:0]   rem;      // restoring-divider partial remainder
    logic [QW-1:0]   num;      // dividend (ed << FRAC), shifted out MSB first
    logic [QW-1:0]   quo;      // quotient bits, shifted in LSB first

    logic [PW-1:0]   exact;
    logic [PW-1:0]   ed_c;
    logic [PW:0]     rem_sh;
    logic            rem_ge;
    logic [PW-1:0]   rem_sub;

    assign a     = idx[PW-1:W];
    assign b     = idx[W-1:0];
    assign exact = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign ed_c  = (c >= exact) ? (c - exact) : (exact - c);

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    // The true difference is always below the divisor, so PW bits suffice.
    assign rem_sh  = {rem, num[QW-1]};
    assign rem_ge  = rem_sh[PW] | (rem_sh[PW-1:0] >= div_r);
    assign rem_sub = rem_sh[PW-1:0] - div_r;

    // Mean over all 2^(2W) pairs is a plain shift of the running sum.
    assign mred = sum_red[4*W+FRAC-1:PW];

    // Sweep controller, divider datapath and accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            cnt           <= '0;
            ed_r          <= '0;
            div_r         <= '0;
            rem           <= '0;
            num           <= '0;
            quo           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            results_valid <= 1'b0;
            err_count     <= '0;
            sum_ed        <= '0;
            max_ed        <= '0;
            sum_red       <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Accumulators are left as-is so a partial run stays visible.
                state         <= S_IDLE;
                busy          <= 1'b0;
                results_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state         <= S_SETTLE;
                            busy          <= 1'b1;
                            idx           <= '0;
                            cnt           <= '0;
                            results_valid <= 1'b0;
                            err_count     <= '0;
                            sum_ed        <= '0;
                            max_ed        <= '0;
                            sum_red       <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt == CW'(DUT_LAT - 1)) state <= S_SAMPLE;
                        else                         cnt   <= cnt + CW'(1);
                    end
                    S_SAMPLE: begin
                        ed_r  <= ed_c;
                        div_r <= exact;
                        rem   <= '0;
                        num   <= {ed_c, {FRAC{1'b0}}};
                        quo   <= '0;
                        cnt   <= '0;
                        // Exact hits and zero products contribute q = 0.
                        if (ed_c == '0 || exact == '0) state <= S_ACCUM;
                        else                           state <= S_DIV;
                    end
                    S_DIV: begin
                        rem <= rem_ge ? rem_sub : rem_sh[PW-1:0];
                        quo <= {quo[QW-2:0], rem_ge};
                        num <= {num[QW-2:0], 1'b0};
                        if (cnt == CW'(QW - 1)) state <= S_ACCUM;
                        else                    cnt   <= cnt + CW'(1);
                    end
                    S_ACCUM: begin
                        err_count <= err_count + {{PW{1'b0}}, (ed_r != '0)};
                        sum_ed    <= sum_ed + {{(PW+1){1'b0}}, ed_r};
                        sum_red   <= sum_red + {{PW{1'b0}}, quo};
                        if (ed_r > max_ed) max_ed <= ed_r;
                        if (idx == '1) begin
                            state         <= S_DONE;
                            done          <= 1'b1;
                            results_valid <= 1'b1;
                        end else begin
                            idx   <= idx + PW'(1);
                            cnt   <= '0;
                            state <= S_SETTLE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_err_engine.sv
// Bench for approx_mult_err_engine: two instances (settle latency 1 and 3),
// each fed by a pipelined behavioural multiplier model; results are checked
// against constants and a pair-by-pair arithmetic reference.
module tb_approx_mult_err_engine;

    localparam int W    = 4;
    localparam int FRAC = 16;
    localparam int QW   = 2 * W + FRAC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                start_s [2];
    logic                abort_s [2];
    logic [W-1:0]        a_s     [2];
    logic [W-1:0]        b_s     [2];
    logic [2*W-1:0]      c_s     [2];
    logic                busy    [2];
    logic                done    [2];
    logic                rv      [2];
    logic [2*W:0]        errc    [2];
    logic [4*W:0]        sed     [2];
    logic [2*W-1:0]      mx      [2];
    logic [4*W+FRAC-1:0] sred    [2];
    logic [2*W+FRAC-1:0] mred    [2];

    int mode [2];
    int lut  [256];
    int nchk = 0;
    int nerr = 0;

    approx_mult_err_engine #(.W(W), .DUT_LAT(1), .FRAC(FRAC)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .busy(busy[0]), .done(done[0]),
        .results_valid(rv[0]), .err_count(errc[0]), .sum_ed(sed[0]),
        .max_ed(mx[0]), .sum_red(sred[0]), .mred(mred[0]));

    approx_mult_err_engine #(.W(W), .DUT_LAT(3), .FRAC(FRAC)) d3 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .busy(busy[1]), .done(done[1]),
        .results_valid(rv[1]), .err_count(errc[1]), .sum_ed(sed[1]),
        .max_ed(mx[1]), .sum_red(sred[1]), .mred(mred[1]));

    // Behaviour of the multiplier under test, selected by mode.
    function automatic int cfun(int m, int x, int y);
        int p;
        p = x * y;
        case (m)
            0: return p;
            1: return 0;
            2: return (x == 1 && y == 1) ? 2 : p;
            3: return p & ~1;
            4: return lut[x * 16 + y];
            default: return (p + 1) & 255;
        endcase
    endfunction

    // Multiplier models with 1- and 3-cycle latency.
    logic [7:0] p0, q0, q1, q2;
    always @(posedge clk) begin
        p0 <= 8'(cfun(mode[0], int'(a_s[0]), int'(b_s[0])));
        q0 <= 8'(cfun(mode[1], int'(a_s[1]), int'(b_s[1])));
        q1 <= q0;
        q2 <= q1;
    end
    assign c_s[0] = p0;
    assign c_s[1] = q2;

    // Operand stability on the latency-3 instance: pairs last >= LAT+2 cycles.
    int   run_len = 100;
    int   viol = 0;
    logic [7:0] prev_ab = 8'h00;
    always @(negedge clk) begin
        if ({a_s[1], b_s[1]} != prev_ab) begin
            if (busy[1] === 1'b1 && rst_n && run_len < 5) viol++;
            run_len = 1;
            prev_ab = {a_s[1], b_s[1]};
        end else begin
            run_len++;
        end
    end

    typedef struct {
        longint err, sed, mx, sred, cyc;
    } res_t;

    // Reference: walk every pair with plain integer arithmetic.
    function automatic res_t model(int m, int lat);
        res_t r;
        int p, cv, ed;
        r.err = 0; r.sed = 0; r.mx = 0; r.sred = 0; r.cyc = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                p  = x * y;
                cv = cfun(m, x, y);
                ed = (cv > p) ? cv - p : p - cv;
                if (ed != 0) r.err++;
                r.sed += ed;
                if (ed > r.mx) r.mx = ed;
                if (p != 0) r.sred += (longint'(ed) << FRAC) / p;
                r.cyc += lat + 2 + ((ed != 0 && p != 0) ? QW : 0);
            end
        end
        return r;
    endfunction

    // Which pair is on a/b during busy cycle n (1 = first cycle after start).
    function automatic int pair_at(int m, int lat, int n);
        int t, p, cv, len;
        t = 0;
        for (int i = 0; i < 256; i++) begin
            p   = (i / 16) * (i % 16);
            cv  = cfun(m, i / 16, i % 16);
            len = lat + 2 + ((cv != p && p != 0) ? QW : 0);
            if (n <= t + len) return i;
            t += len;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input int s, input string tag);
        chk({tag, "_busy"}, 64'(busy[s]), 0);
        chk({tag, "_done"}, 64'(done[s]), 0);
        chk({tag, "_rv"},   64'(rv[s]),   0);
        chk({tag, "_ab"},   64'({a_s[s], b_s[s]}), 0);
        chk({tag, "_err"},  64'(errc[s]), 0);
        chk({tag, "_sed"},  64'(sed[s]),  0);
        chk({tag, "_max"},  64'(mx[s]),   0);
        chk({tag, "_sred"}, 64'(sred[s]), 0);
        chk({tag, "_mred"}, 64'(mred[s]), 0);
    endtask

    // Pulse start at a negedge, then count busy cycles until done (bounded).
    task automatic run_sweep(input int s, output int bc);
        int g;
        bc = 0;
        g  = 0;
        start_s[s] = 1'b1;
        @(negedge clk);
        start_s[s] = 1'b0;
        while (done[s] !== 1'b1 && g < 20000) begin
            if (busy[s] === 1'b1) bc++;
            g++;
            @(negedge clk);
        end
    endtask

    task automatic check_sweep(input int s, input string tag, input longint e_err,
                               input longint e_sed, input longint e_mx,
                               input longint e_sred, input longint e_cyc);
        int bc;
        run_sweep(s, bc);
        chk({tag, "_done"},   64'(done[s]), 1);
        chk({tag, "_cycles"}, 64'(bc), 64'(e_cyc));
        chk({tag, "_rv"},     64'(rv[s]), 1);
        chk({tag, "_err"},    64'(errc[s]), 64'(e_err));
        chk({tag, "_sed"},    64'(sed[s]),  64'(e_sed));
        chk({tag, "_max"},    64'(mx[s]),   64'(e_mx));
        chk({tag, "_sred"},   64'(sred[s]), 64'(e_sred));
        chk({tag, "_mred"},   64'(mred[s]), 64'(e_sred >> (2 * W)));
        @(negedge clk);
        chk({tag, "_busy_fall"}, 64'(busy[s]), 0);
        chk({tag, "_done_pulse"}, 64'(done[s]), 0);
        chk({tag, "_hold"},   64'(sed[s]),  64'(e_sed));
    endtask

    typedef struct {
        int     sel;
        int     md;
        longint err, sed, mx, sred, cyc;
    } vec_t;

    vec_t vt [6];

    initial begin
        res_t r;
        int   seen_done;
        for (int s = 0; s < 2; s++) begin
            start_s[s] = 1'b0;
            abort_s[s] = 1'b0;
            mode[s]    = 0;
        end
        for (int i = 0; i < 256; i++) begin
            lut[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255))
                                                 : (i / 16) * (i % 16);
        end

        // Vectors: spec constants where known, reference model otherwise.
        r = model(1, 1);
        vt[0] = '{0, 0, 0, 0, 0, 0, 768};
        vt[1] = '{0, 1, 225, 14400, 225, 14745600, r.cyc};
        r = model(2, 1);
        vt[2] = '{0, 2, 1, 1, 1, 65536, r.cyc};
        r = model(3, 3);
        vt[3] = '{1, 3, 64, 64, 1, r.sred, r.cyc};
        r = model(4, 1);
        vt[4] = '{0, 4, r.err, r.sed, r.mx, r.sred, r.cyc};
        r = model(4, 3);
        vt[5] = '{1, 4, r.err, r.sed, r.mx, r.sred, r.cyc};

        #12;
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            mode[vt[i].sel] = vt[i].md;
            @(negedge clk);
            check_sweep(vt[i].sel, $sformatf("vec%0d", i), vt[i].err, vt[i].sed,
                        vt[i].mx, vt[i].sred, vt[i].cyc);
        end

        // start and abort together in IDLE: abort wins.
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        chk("idle_abort_wins_busy", 64'(busy[0]), 0);

        // Mid-sweep start is ignored; abort at cycle 300 keeps partial sums.
        mode[0] = 2;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        seen_done = 0;
        for (int n = 1; n <= 300; n++) begin
            if (n == 102) chk("start_ignored_ab", 64'({a_s[0], b_s[0]}), 64'(pair_at(2, 1, 102)));
            if (done[0] === 1'b1) seen_done++;
            start_s[0] = (n == 100);
            abort_s[0] = (n == 300);
            @(negedge clk);
        end
        abort_s[0] = 1'b0;
        chk("abort_busy",   64'(busy[0]), 0);
        chk("abort_done",   64'(done[0]), 0);
        chk("abort_rv",     64'(rv[0]),   0);
        chk("abort_err",    64'(errc[0]), 1);
        chk("abort_sed",    64'(sed[0]),  1);
        chk("abort_max",    64'(mx[0]),   1);
        chk("abort_sred",   64'(sred[0]), 65536);
        chk("abort_mred",   64'(mred[0]), 256);
        for (int n = 0; n < 5; n++) begin
            if (done[0] === 1'b1 || busy[0] === 1'b1) seen_done++;
            @(negedge clk);
        end
        chk("abort_no_done_or_busy", 64'(seen_done), 0);
        mode[0] = 0;
        @(negedge clk);
        check_sweep(0, "after_abort", 0, 0, 0, 0, 768);

        // Asynchronous reset while the latency-3 instance is dividing pair 17.
        mode[1] = 5;
        @(negedge clk);
        start_s[1] = 1'b1;
        @(negedge clk);
        start_s[1] = 1'b0;
        for (int n = 1; n < 100; n++) @(negedge clk);
        chk("mid_err", 64'(errc[1]), 17);
        chk("mid_sed", 64'(sed[1]), 17);
        #1 rst_n = 1'b0;
        #1;
        chk_zero(1, "async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        r = model(5, 3);
        check_sweep(1, "after_rst", r.err, r.sed, r.mx, r.sred, r.cyc);

        chk("ab_stable_lat3", 64'(viol), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
